// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller: shift-register scoreboard of in-flight GPR writes,
// Tuse/Tnew stall resolution and D-stage forward selects, plus the HI/LO busy counter.
module hazard_scoreboard #(
  parameter int unsigned DEPTH       = 3,
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned TNEW_W      = 2,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned SEL_W       = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [TNEW_W-1:0] d_rs_tuse,
  input  logic [REG_AW-1:0] d_rt,
  input  logic [TNEW_W-1:0] d_rt_tuse,
  input  logic              d_we,
  input  logic [REG_AW-1:0] d_dst,
  input  logic [TNEW_W-1:0] d_tnew,
  input  logic              d_md_use,
  input  logic              e_md_start,
  input  logic              e_md_is_div,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_sel_rs,
  output logic [SEL_W-1:0]  fwd_sel_rt,
  output logic              md_busy
);

  localparam int unsigned CNT_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  logic              r_valid [1:DEPTH];
  logic [REG_AW-1:0] r_dst   [1:DEPTH];
  logic [TNEW_W-1:0] r_tnew  [1:DEPTH];
  logic [CNT_W-1:0]  r_md_cnt;

  // Lookup chains run from the oldest entry toward entry 1 so the youngest writer wins.
  logic [SEL_W-1:0]  w_rs_sel [1:DEPTH+1];
  logic [SEL_W-1:0]  w_rt_sel [1:DEPTH+1];
  logic              w_rs_haz [1:DEPTH+1];
  logic              w_rt_haz [1:DEPTH+1];

  // Entry 1: a stalled D instruction becomes an invalid bubble, so it never matches itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid[1] <= 1'b0;
      r_dst[1]   <= '0;
      r_tnew[1]  <= '0;
    end else if (stall) begin
      r_valid[1] <= 1'b0;
      r_dst[1]   <= '0;
      r_tnew[1]  <= '0;
    end else begin
      r_valid[1] <= d_we && (d_dst != '0);
      r_dst[1]   <= d_dst;
      r_tnew[1]  <= d_tnew;
    end
  end

  for (genvar k = 2; k <= DEPTH; k++) begin : g_shift
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_valid[k] <= 1'b0;
        r_dst[k]   <= '0;
        r_tnew[k]  <= '0;
      end else begin
        r_valid[k] <= r_valid[k-1];
        r_dst[k]   <= r_dst[k-1];
        r_tnew[k]  <= (r_tnew[k-1] != '0) ? r_tnew[k-1] - TNEW_W'(1) : '0;
      end
    end
  end

  assign w_rs_sel[DEPTH+1] = '0;
  assign w_rt_sel[DEPTH+1] = '0;
  assign w_rs_haz[DEPTH+1] = 1'b0;
  assign w_rt_haz[DEPTH+1] = 1'b0;

  for (genvar k = 1; k <= DEPTH; k++) begin : g_lookup
    logic w_hit_rs;
    logic w_hit_rt;
    logic w_rdy;
    assign w_hit_rs = r_valid[k] && (d_rs != '0) && (r_dst[k] == d_rs);
    assign w_hit_rt = r_valid[k] && (d_rt != '0) && (r_dst[k] == d_rt);
    assign w_rdy    = (r_tnew[k] == '0);
    assign w_rs_sel[k] = w_hit_rs ? (w_rdy ? SEL_W'(k) : '0) : w_rs_sel[k+1];
    assign w_rt_sel[k] = w_hit_rt ? (w_rdy ? SEL_W'(k) : '0) : w_rt_sel[k+1];
    assign w_rs_haz[k] = w_hit_rs ? (r_tnew[k] > d_rs_tuse) : w_rs_haz[k+1];
    assign w_rt_haz[k] = w_hit_rt ? (r_tnew[k] > d_rt_tuse) : w_rt_haz[k+1];
  end

  // A start that arrives while the unit is busy is dropped, not queued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_md_cnt <= '0;
    end else if (e_md_start && (r_md_cnt == '0)) begin
      r_md_cnt <= e_md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (r_md_cnt != '0) begin
      r_md_cnt <= r_md_cnt - CNT_W'(1);
    end
  end

  assign md_busy    = (r_md_cnt != '0);
  assign fwd_sel_rs = w_rs_sel[1];
  assign fwd_sel_rt = w_rt_sel[1];
  assign stall      = w_rs_haz[1] | w_rt_haz[1] | (d_md_use & (md_busy | e_md_start));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, ALU forwarding, writer priority,
// mult/div busy window and asynchronous reset mid-operation.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] d_rs_tuse, d_rt_tuse, d_tnew;
  logic       d_we, d_md_use, e_md_start, e_md_is_div;
  logic       stall, md_busy;
  logic [1:0] fwd_sel_rs, fwd_sel_rt;

  int n_vec = 0;
  int n_err = 0;

  hazard_scoreboard #(
    .DEPTH(3), .REG_AW(5), .TNEW_W(2), .MULT_CYCLES(5), .DIV_CYCLES(10), .SEL_W(2)
  ) dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rs_tuse(d_rs_tuse), .d_rt(d_rt), .d_rt_tuse(d_rt_tuse),
    .d_we(d_we), .d_dst(d_dst), .d_tnew(d_tnew), .d_md_use(d_md_use),
    .e_md_start(e_md_start), .e_md_is_div(e_md_is_div),
    .stall(stall), .fwd_sel_rs(fwd_sel_rs), .fwd_sel_rt(fwd_sel_rt), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_d(input logic [4:0] rs, input logic [1:0] rs_tu, input logic [4:0] rt,
                       input logic [1:0] rt_tu, input logic we, input logic [4:0] dst,
                       input logic [1:0] tnew, input logic md_use);
    d_rs = rs; d_rs_tuse = rs_tu; d_rt = rt; d_rt_tuse = rt_tu;
    d_we = we; d_dst = dst; d_tnew = tnew; d_md_use = md_use;
  endtask

  task automatic flush();
    @(negedge clk);
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    e_md_start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; e_md_start = 1'b0; e_md_is_div = 1'b0;
    set_d(9, 0, 9, 0, 1, 9, 2, 0);
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: stall=%0b want 0", stall); end
    n_vec++; if (fwd_sel_rs !== 2'd0) begin n_err++; $display("FAIL rst_sel_rs: sel=%0d want 0", fwd_sel_rs); end
    n_vec++; if (fwd_sel_rt !== 2'd0) begin n_err++; $display("FAIL rst_sel_rt: sel=%0d want 0", fwd_sel_rt); end
    n_vec++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: busy=%0b want 0", md_busy); end
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_load_use();
    @(negedge clk);
    set_d(0, 0, 0, 0, 1, 9, 2, 0);
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu_issue: stall=%0b want 0", stall); end
    @(negedge clk);
    set_d(9, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL lu_stall1: stall=%0b want 1", stall); end
    n_vec++; if (fwd_sel_rs !== 2'd0) begin n_err++; $display("FAIL lu_sel1: sel=%0d want 0", fwd_sel_rs); end
    @(negedge clk); #1;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL lu_stall2: stall=%0b want 1", stall); end
    @(negedge clk); #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu_stall3: stall=%0b want 0", stall); end
    n_vec++; if (fwd_sel_rs !== 2'd3) begin n_err++; $display("FAIL lu_sel3: sel=%0d want 3", fwd_sel_rs); end
    flush();
  endtask

  task automatic test_alu_back_to_back();
    @(negedge clk);
    set_d(0, 0, 0, 0, 1, 8, 1, 0);
    @(negedge clk);
    set_d(8, 1, 0, 0, 1, 10, 1, 0);
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL alu_stall: stall=%0b want 0", stall); end
    n_vec++; if (fwd_sel_rs !== 2'd0) begin n_err++; $display("FAIL alu_sel_e1: sel=%0d want 0", fwd_sel_rs); end
    set_d(8, 1, 8, 0, 1, 10, 1, 0);
    #1;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL alu_rt_tuse0: stall=%0b want 1", stall); end
    n_vec++; if (fwd_sel_rt !== 2'd0) begin n_err++; $display("FAIL alu_rt_sel: sel=%0d want 0", fwd_sel_rt); end
    set_d(8, 1, 0, 0, 1, 10, 1, 0);
    @(negedge clk);
    set_d(8, 1, 10, 1, 0, 0, 0, 0);
    #1;
    n_vec++; if (fwd_sel_rs !== 2'd2) begin n_err++; $display("FAIL alu_sel_e2: sel=%0d want 2", fwd_sel_rs); end
    n_vec++; if (fwd_sel_rt !== 2'd0) begin n_err++; $display("FAIL alu_rt_e1: sel=%0d want 0", fwd_sel_rt); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL alu_stall_e2: stall=%0b want 0", stall); end
    flush();
  endtask

  task automatic test_priority();
    @(negedge clk); set_d(0, 0, 0, 0, 1, 5, 0, 0);
    @(negedge clk); set_d(0, 0, 0, 0, 1, 7, 0, 0);
    @(negedge clk); set_d(0, 0, 0, 0, 1, 5, 0, 0);
    @(negedge clk); set_d(7, 0, 5, 0, 0, 0, 0, 0);
    #1;
    n_vec++; if (fwd_sel_rt !== 2'd1) begin n_err++; $display("FAIL prio_rt: sel=%0d want 1", fwd_sel_rt); end
    n_vec++; if (fwd_sel_rs !== 2'd2) begin n_err++; $display("FAIL prio_rs: sel=%0d want 2", fwd_sel_rs); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL prio_stall: stall=%0b want 0", stall); end
    @(negedge clk); set_d(0, 0, 0, 0, 1, 5, 2, 0);
    @(negedge clk); set_d(5, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL prio_young_stall: stall=%0b want 1", stall); end
    n_vec++; if (fwd_sel_rs !== 2'd0) begin n_err++; $display("FAIL prio_young_sel: sel=%0d want 0", fwd_sel_rs); end
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    flush();
    @(negedge clk); set_d(0, 0, 0, 0, 1, 0, 2, 0);
    @(negedge clk); set_d(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL r0_stall: stall=%0b want 0", stall); end
    n_vec++; if (fwd_sel_rs !== 2'd0) begin n_err++; $display("FAIL r0_sel: sel=%0d want 0", fwd_sel_rs); end
    flush();
  endtask

  task automatic test_muldiv();
    int busy_cnt;
    @(negedge clk);
    set_d(0, 0, 0, 0, 0, 0, 0, 1);
    e_md_start = 1'b1; e_md_is_div = 1'b1;
    #1;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL md_start_stall: stall=%0b want 1", stall); end
    n_vec++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL md_start_busy: busy=%0b want 0", md_busy); end
    @(negedge clk);
    e_md_start = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (md_busy === 1'b1) busy_cnt++;
      n_vec++; if (md_busy !== (i < 10)) begin n_err++; $display("FAIL div_busy_%0d: busy=%0b want %0b", i, md_busy, (i < 10)); end
      n_vec++; if (stall !== (i < 10)) begin n_err++; $display("FAIL mflo_stall_%0d: stall=%0b want %0b", i, stall, (i < 10)); end
      @(negedge clk);
    end
    n_vec++; if (busy_cnt != 10) begin n_err++; $display("FAIL div_busy_len: cycles=%0d want 10", busy_cnt); end
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    e_md_start = 1'b1; e_md_is_div = 1'b0;
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL mult_nouse_stall: stall=%0b want 0", stall); end
    @(negedge clk);
    e_md_is_div = 1'b1;
    #1;
    n_vec++; if (md_busy !== 1'b1) begin n_err++; $display("FAIL mult_busy: busy=%0b want 1", md_busy); end
    @(negedge clk);
    e_md_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_vec++; if (md_busy !== (i < 4)) begin n_err++; $display("FAIL mult_busy_%0d: busy=%0b want %0b", i, md_busy, (i < 4)); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    set_d(0, 0, 0, 0, 1, 1, 2, 0);
    e_md_start = 1'b1; e_md_is_div = 1'b1;
    @(negedge clk); e_md_start = 1'b0; set_d(0, 0, 0, 0, 1, 2, 2, 0);
    @(negedge clk); set_d(0, 0, 0, 0, 1, 3, 2, 0);
    @(negedge clk); set_d(0, 0, 0, 0, 1, 4, 2, 0);
    @(negedge clk); set_d(3, 0, 2, 0, 0, 0, 0, 1);
    #1;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL mid_pre_stall: stall=%0b want 1", stall); end
    n_vec++; if (md_busy !== 1'b1) begin n_err++; $display("FAIL mid_pre_busy: busy=%0b want 1", md_busy); end
    n_vec++; if (fwd_sel_rt !== 2'd3) begin n_err++; $display("FAIL mid_pre_sel_rt: sel=%0d want 3", fwd_sel_rt); end
    #1;
    reset = 1'b0;
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL mid_rst_stall: stall=%0b want 0", stall); end
    n_vec++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: busy=%0b want 0", md_busy); end
    n_vec++; if (fwd_sel_rs !== 2'd0) begin n_err++; $display("FAIL mid_rst_sel_rs: sel=%0d want 0", fwd_sel_rs); end
    n_vec++; if (fwd_sel_rt !== 2'd0) begin n_err++; $display("FAIL mid_rst_sel_rt: sel=%0d want 0", fwd_sel_rt); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL mid_post_stall: stall=%0b want 0", stall); end
    n_vec++; if (fwd_sel_rt !== 2'd0) begin n_err++; $display("FAIL mid_post_sel_rt: sel=%0d want 0", fwd_sel_rt); end
    flush();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_alu_back_to_back();
    test_priority();
    test_muldiv();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
